// File: rtl/out_stream_scheduler.sv
// ---------------------------------------------------------------------------
// out_stream_scheduler
//
// Round-robin packet scheduler for one ULSS output stream. Every cycle it
// decides which mapped input stream's packet store is read next and presents
// the decision as a 5-bit code on next_state (0 = IDLE, k+1 = SERVE_k). The
// grant_arbiter turns that code into the packet-store read enables. A
// selection is held for a whole packet and only moves on end-of-packet.
//
// Optional feature macro: ULSS_SCHED_TIMEOUT_EN
//   Defined     : a per-packet watchdog aborts a SERVE state that has not seen
//                 pck_rd_last after TIMEOUT_CYCLES cycles and pulses
//                 timeout_err.
//   Not defined : SERVE waits indefinitely, timeout_err is constant 0.
//
// Parameters
//   NUM_IN          number of input streams (16; the state code assumes it)
//   TIMEOUT_CYCLES  watchdog limit per packet (used only with the macro)
//
// Ports
//   clk             clock
//   rst             synchronous, active-high reset
//   stream_mapping  bit k: input stream k is routed to this output stream
//   pck_avail       bit k: packet store k holds at least one complete packet
//   token_count_en  bit k: input stream k has tokens
//   out_ready       output stream can start a new packet
//   pck_rd_last     last word of the granted packet is read this cycle
//   next_state      combinational next state code (drives grant_arbiter)
//   cur_state       registered state code (also the FSM debug view)
//   pck_done        one-cycle pulse, the cycle after a completed packet
//   pck_count       completed-packet counter, wraps 0xFFFF -> 0
//   timeout_err     one-cycle pulse the cycle after a watchdog abort
//
// Handshake: a packet starts in the cycle next_state moves to a SERVE code
// (the read enable is asserted in that same cycle) and completes in the cycle
// pck_rd_last is high while cur_state is a SERVE code. pck_rd_last seen in
// IDLE is not a completion and is ignored. Eligibility inputs (mapping,
// avail, tokens, out_ready) are only looked at when a new packet can start.
// ---------------------------------------------------------------------------
module out_stream_scheduler #(
  parameter int NUM_IN         = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_IN-1:0] stream_mapping,
  input  logic [NUM_IN-1:0] pck_avail,
  input  logic [NUM_IN-1:0] token_count_en,
  input  logic              out_ready,
  input  logic              pck_rd_last,
  output logic [4:0]        next_state,
  output logic [4:0]        cur_state,
  output logic              pck_done,
  output logic [15:0]       pck_count,
  output logic              timeout_err
);

  // State codes are fixed by the grant_arbiter interface: IDLE is 0 and
  // SERVE_k is k+1.
  typedef enum logic [4:0] {
    ST_IDLE     = 5'd0,
    ST_SERVE_0  = 5'd1,
    ST_SERVE_1  = 5'd2,
    ST_SERVE_2  = 5'd3,
    ST_SERVE_3  = 5'd4,
    ST_SERVE_4  = 5'd5,
    ST_SERVE_5  = 5'd6,
    ST_SERVE_6  = 5'd7,
    ST_SERVE_7  = 5'd8,
    ST_SERVE_8  = 5'd9,
    ST_SERVE_9  = 5'd10,
    ST_SERVE_10 = 5'd11,
    ST_SERVE_11 = 5'd12,
    ST_SERVE_12 = 5'd13,
    ST_SERVE_13 = 5'd14,
    ST_SERVE_14 = 5'd15,
    ST_SERVE_15 = 5'd16
  } state_t;

  // Registers
  state_t      r_state;
  logic [3:0]  r_ptr;        // last input that was granted
  logic        r_pck_done;
  logic [15:0] r_pck_count;

  // Combinational
  logic [NUM_IN-1:0] w_elig;
  logic              w_in_serve;
  logic [3:0]        w_search_start;
  logic [3:0]        w_scan_idx;
  logic [3:0]        w_pick_idx;
  logic              w_pick_found;
  state_t            w_pick_state;
  state_t            w_next;
  logic              w_accept_last;
  logic              w_enter;
  logic              w_timeout;

  assign cur_state = r_state;
  assign next_state = w_next;
  assign pck_done  = r_pck_done;
  assign pck_count = r_pck_count;

  // An input can be started only if it is mapped here, has a complete
  // packet, has tokens, and the output side can take a new packet.
  assign w_elig = stream_mapping & pck_avail & token_count_en & {NUM_IN{out_ready}};

  // Codes above SERVE_15 cannot be reached; they are treated like IDLE so a
  // corrupted register recovers on its own.
  assign w_in_serve = (r_state != ST_IDLE) && (r_state <= ST_SERVE_15);

  // In SERVE_k the state code k+1 is itself the search start (mod 16), so
  // the input just served ends up with the lowest priority. In IDLE the
  // search starts one past the last input served.
  assign w_search_start = w_in_serve ? cur_state[3:0] : (r_ptr + 4'd1);

  // Circular first-one search over 16 positions starting at w_search_start.
  always_comb begin
    w_pick_found = 1'b0;
    w_pick_idx   = 4'd0;
    w_scan_idx   = 4'd0;
    for (int i = 0; i < NUM_IN; i++) begin
      w_scan_idx = w_search_start + 4'(i);
      if (!w_pick_found && w_elig[w_scan_idx]) begin
        w_pick_found = 1'b1;
        w_pick_idx   = w_scan_idx;
      end
    end
  end

  assign w_pick_state = state_t'({1'b0, w_pick_idx} + 5'd1);

  assign w_accept_last = w_in_serve && pck_rd_last;

  // Next-state decision. Reset forces IDLE combinationally so no grant is
  // ever issued while rst is high. In SERVE the eligibility inputs are
  // deliberately ignored until the packet ends.
  always_comb begin
    w_next = r_state;
    if (rst) begin
      w_next = ST_IDLE;
    end else if (!w_in_serve) begin
      w_next = w_pick_found ? w_pick_state : ST_IDLE;
    end else if (pck_rd_last) begin
      w_next = w_pick_found ? w_pick_state : ST_IDLE;
    end else if (w_timeout) begin
      w_next = ST_IDLE;
    end else begin
      w_next = r_state;
    end
  end

  // A new packet starts whenever a SERVE code is chosen from IDLE or at the
  // end of a packet, including a back-to-back repeat of the same input.
  assign w_enter = (w_next != ST_IDLE) && (!w_in_serve || pck_rd_last);

  // Scheduler FSM and packet bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_ptr       <= 4'hF;
      r_pck_done  <= 1'b0;
      r_pck_count <= 16'd0;
    end else begin
      r_state    <= w_next;
      r_pck_done <= w_accept_last;
      if (w_enter) begin
        r_ptr <= w_pick_idx;
      end
      if (w_accept_last) begin
        r_pck_count <= r_pck_count + 16'd1;
      end
    end
  end

`ifdef ULSS_SCHED_TIMEOUT_EN
  // The counter holds 0..TIMEOUT_CYCLES-1; the limit is reached on the
  // TIMEOUT_CYCLES-th cycle spent in SERVE.
  localparam int WDOG_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WDOG_W-1:0] WDOG_LIMIT = WDOG_W'(TIMEOUT_CYCLES - 1);

  logic [WDOG_W-1:0] r_wdog;
  logic              r_timeout_err;

  // pck_rd_last in the limit cycle is a normal completion, not an abort.
  assign w_timeout   = w_in_serve && !pck_rd_last && (r_wdog == WDOG_LIMIT);
  assign timeout_err = r_timeout_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wdog        <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_timeout_err <= w_timeout;
      if (w_enter) begin
        r_wdog <= '0;
      end else if (w_in_serve) begin
        r_wdog <= r_wdog + 1'b1;
      end
    end
  end
`else
  logic w_unused_cfg;

  assign w_timeout    = 1'b0;
  assign timeout_err  = 1'b0;
  assign w_unused_cfg = (TIMEOUT_CYCLES > 0);
`endif

endmodule

// File: tb/tb_out_stream_scheduler.sv
// ---------------------------------------------------------------------------
// tb_out_stream_scheduler
//
// Drives the scheduler from initial-block tasks, computes the expected
// next_state / cur_state / pck_done / pck_count / timeout_err every cycle
// from a small behavioural model of the round-robin rules, and adds directed
// checks for the corner cases (wrap, back-to-back, mid-packet input changes,
// reset mid-packet, watchdog).
// ---------------------------------------------------------------------------
module tb_out_stream_scheduler;

`ifdef ULSS_SCHED_TIMEOUT_EN
  localparam int TO    = 8;
  localparam bit TO_EN = 1'b1;
`else
  localparam int TO    = 1024;
  localparam bit TO_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [15:0] stream_mapping;
  logic [15:0] pck_avail;
  logic [15:0] token_count_en;
  logic        out_ready;
  logic        pck_rd_last;
  logic [4:0]  next_state;
  logic [4:0]  cur_state;
  logic        pck_done;
  logic [15:0] pck_count;
  logic        timeout_err;

  out_stream_scheduler #(
    .NUM_IN(16),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .stream_mapping(stream_mapping),
    .pck_avail(pck_avail),
    .token_count_en(token_count_en),
    .out_ready(out_ready),
    .pck_rd_last(pck_rd_last),
    .next_state(next_state),
    .cur_state(cur_state),
    .pck_done(pck_done),
    .pck_count(pck_count),
    .timeout_err(timeout_err)
  );

  // ---------------- scoreboard ----------------
  int n_total = 0;
  int n_bad   = 0;
  logic [4:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // m_cur: 0 idle, k+1 serving input k. m_ptr: last input granted.
  int          m_cur;
  int          m_ptr;
  int          m_wd;
  int          m_nxt;
  logic [15:0] m_count;
  bit          m_done;
  bit          m_terr;

  function automatic int m_pick(input int start);
    for (int i = 0; i < 16; i++) begin
      int idx = (start + i) % 16;
      if (stream_mapping[idx] && pck_avail[idx] && token_count_en[idx] && out_ready)
        return idx + 1;
    end
    return 0;
  endfunction

  function automatic int m_next();
    if (rst) return 0;
    if (m_cur == 0) return m_pick((m_ptr + 1) % 16);
    if (pck_rd_last) return m_pick(m_cur % 16);
    if (TO_EN && (m_wd == TO - 1)) return 0;
    return m_cur;
  endfunction

  task automatic model_reset();
    m_cur   = 0;
    m_ptr   = 15;
    m_wd    = 0;
    m_count = 16'd0;
    m_done  = 1'b0;
    m_terr  = 1'b0;
  endtask

  // ---------------- driver tasks ----------------
  // Inputs are changed right after a falling edge; outputs are sampled 1 ns
  // later and the model advances at the rising edge.
  task automatic settle_and_check();
    #1;
    m_nxt = m_next();
    check("next_state",  next_state,  m_nxt);
    check("cur_state",   cur_state,   m_cur);
    check("pck_done",    pck_done,    m_done);
    check("pck_count",   pck_count,   m_count);
    check("timeout_err", timeout_err, m_terr);
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      bit acc;
      bit tmo;
      acc = (m_cur != 0) && pck_rd_last;
      tmo = (m_cur != 0) && !pck_rd_last && TO_EN && (m_wd == TO - 1);
      m_done = acc;
      m_terr = tmo;
      if (acc) m_count = m_count + 16'd1;
      if (m_nxt != 0 && (m_cur == 0 || pck_rd_last)) begin
        m_wd  = 0;
        m_ptr = m_nxt - 1;
      end else if (m_cur != 0) begin
        m_wd++;
      end
      m_cur = m_nxt;
    end
    @(negedge clk);
  endtask

  task automatic step();
    settle_and_check();
    tick();
  endtask

  task automatic set_in(input logic [15:0] map, input logic [15:0] av,
                        input logic [15:0] tok, input logic rdy, input logic last);
    stream_mapping = map;
    pck_avail      = av;
    token_count_en = tok;
    out_ready      = rdy;
    pck_rd_last    = last;
  endtask

  // Ends any packet in flight with nothing eligible, then idles one cycle.
  task automatic go_idle();
    set_in(16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b1);
    step();
    pck_rd_last = 1'b0;
    step();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    set_in(16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset state, with everything eligible: still no grant.
    step();
    rst = 1'b0;

    // Four mapped inputs, packet ends every 4th serve cycle.
    set_in(16'h000F, 16'h000F, 16'h000F, 1'b1, 1'b0);
    exp_q = {5'd1, 5'd2, 5'd3, 5'd4, 5'd1, 5'd2, 5'd3, 5'd4};
    settle_and_check();
    check("rr_seq", next_state, exp_q.pop_front());
    tick();
    for (int p = 0; p < 7; p++) begin
      for (int c = 0; c < 4; c++) begin
        pck_rd_last = (c == 3);
        settle_and_check();
        if (c == 3) check("rr_seq", next_state, exp_q.pop_front());
        tick();
      end
    end
    pck_rd_last = 1'b0;

    // Randomised traffic including occasional resets.
    for (int n = 0; n < 400; n++) begin
      set_in(16'($urandom()), 16'($urandom()), 16'($urandom()),
             ($urandom_range(0, 7) != 0), ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 3) == 0) stream_mapping = 16'hFFFF;
      rst = ($urandom_range(0, 99) == 0);
      step();
    end
    rst = 1'b0;
    go_idle();

    // Single eligible input 9: zero-latency grant, then back-to-back.
    set_in(16'hFFFF, 16'h0000, 16'h0000, 1'b1, 1'b0);
    step();
    pck_avail      = 16'h0200;
    token_count_en = 16'h0200;
    settle_and_check();
    check("in9_grant", next_state, 5'd10);
    tick();
    repeat (3) step();
    pck_rd_last = 1'b1;
    settle_and_check();
    check("in9_b2b", next_state, 5'd10);
    tick();
    pck_rd_last = 1'b0;
    go_idle();

    // SERVE_3 with its eligibility pulled away mid-packet.
    set_in(16'h0008, 16'h0008, 16'h0008, 1'b1, 1'b0);
    settle_and_check();
    check("s3_grant", next_state, 5'd4);
    tick();
    out_ready      = 1'b0;
    token_count_en = 16'h0000;
    stream_mapping = 16'h0000;
    for (int n = 0; n < 5; n++) begin
      settle_and_check();
      check("s3_hold", next_state, 5'd4);
      tick();
    end
    pck_rd_last = 1'b1;
    settle_and_check();
    check("s3_end", next_state, 5'd0);
    tick();
    pck_rd_last = 1'b0;

    // Reset during SERVE_5 (count starts from 0 so it must stay 0).
    set_in(16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_in(16'h0020, 16'h0020, 16'h0020, 1'b1, 1'b0);
    step();
    step();
    rst = 1'b1;
    settle_and_check();
    check("rst5_next", next_state, 5'd0);
    tick();
    rst = 1'b0;
    set_in(16'h0021, 16'h0021, 16'h0021, 1'b1, 1'b0);
    settle_and_check();
    check("rst5_cur",   cur_state, 5'd0);
    check("rst5_count", pck_count, 16'd0);
    check("rst5_first", next_state, 5'd1);
    tick();
    go_idle();

    // Inputs 0 and 15 with ptr=15: 0, 15, 0.
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_in(16'h8001, 16'h8001, 16'h8001, 1'b1, 1'b0);
    settle_and_check();
    check("wrap_0", next_state, 5'd1);
    tick();
    step();
    pck_rd_last = 1'b1;
    settle_and_check();
    check("wrap_15", next_state, 5'd16);
    tick();
    pck_rd_last = 1'b0;
    step();
    pck_rd_last = 1'b1;
    settle_and_check();
    check("wrap_back", next_state, 5'd1);
    tick();
    pck_rd_last = 1'b0;
    go_idle();

    // SERVE_2 with no end-of-packet.
    set_in(16'h0004, 16'h0004, 16'h0004, 1'b1, 1'b0);
    settle_and_check();
    check("to_grant", next_state, 5'd3);
    tick();
`ifdef ULSS_SCHED_TIMEOUT_EN
    for (int i = 1; i <= 8; i++) begin
      settle_and_check();
      if (i < 8) check("to_hold", next_state, 5'd3);
      else       check("to_fire", next_state, 5'd0);
      tick();
    end
    settle_and_check();
    check("to_err", timeout_err, 1'b1);
    check("to_cnt", pck_count, m_count);
    tick();
    settle_and_check();
    check("to_err_once", timeout_err, 1'b0);
    tick();
`else
    for (int i = 0; i < 120; i++) step();
    settle_and_check();
    check("no_to_hold", next_state, 5'd3);
    check("no_to_err", timeout_err, 1'b0);
    tick();
`endif
    go_idle();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
